// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package riscv_fetch_pkg;

    localparam int INSTR_W = 32;

    // addi x0,x0,0 -- shown on the fetch output whenever nothing valid is held
    localparam logic [INSTR_W-1:0] IF_NOP_INSTR = 32'h0000_0013;
    localparam logic [INSTR_W-1:0] IF_RESET_PC  = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/ifetch_stage_if.sv
// Fetch-to-decode handshake: the fetch stage is master, decode is slave.
interface ifetch_stage_if;
    import riscv_fetch_pkg::*;

    logic               if_valid;
    logic               if_ready;
    logic [INSTR_W-1:0] if_instr;
    logic [INSTR_W-1:0] if_pc;
    logic [INSTR_W-1:0] if_pc_plus4;

    modport master (
        output if_valid,
        output if_instr,
        output if_pc,
        output if_pc_plus4,
        input  if_ready
    );

    modport slave (
        input  if_valid,
        input  if_instr,
        input  if_pc,
        input  if_pc_plus4,
        output if_ready
    );

endinterface

// File: rtl/ifetch_pc_gen.sv
// Program counter with hold / +4 / redirect next-pc selection and target alignment check.
module ifetch_pc_gen
    import riscv_fetch_pkg::*;
#(
    parameter logic [INSTR_W-1:0] RESET_PC = IF_RESET_PC
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               advance,
    input  logic               redirect_valid,
    input  logic [INSTR_W-1:0] redirect_pc,
    output logic [INSTR_W-1:0] pc,
    output logic               misalign
);

    assign misalign = (redirect_pc[1:0] != 2'b00);

    // A misaligned redirect leaves the pc untouched; the stage parks in FAULT instead.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (redirect_valid && !misalign) begin
            pc <= redirect_pc;
        end else if (advance) begin
            pc <= pc + 32'd4;
        end
    end

endmodule

// File: rtl/ifetch_stage.sv
// Instruction fetch stage: drives the imem address from the pc and registers one instruction for decode.
module ifetch_stage
    import riscv_fetch_pkg::*;
#(
    parameter logic [INSTR_W-1:0] RESET_PC  = IF_RESET_PC,
    parameter logic [INSTR_W-1:0] NOP_INSTR = IF_NOP_INSTR
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    output logic [31:0]        imem_addr,
    output logic               imem_rw,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    ifetch_stage_if.master     dec,
    output logic               fetch_fault,
    output logic [31:0]        fetch_count
);

    fetch_state_e       state;
    logic [INSTR_W-1:0] pc;
    logic               misalign;
    logic               ld;
    logic               capture;

    assign ld      = !dec.if_valid || dec.if_ready;
    assign capture = (state == FETCH) && run && ld && !redirect_valid;

    assign imem_addr = {2'b00, pc[31:2]};
    assign imem_rw   = 1'b1;

    ifetch_pc_gen #(
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk            (clk),
        .reset          (reset),
        .advance        (capture),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc             (pc),
        .misalign       (misalign)
    );

    // Redirect outranks everything: it kills the held instruction even if decode takes it this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            dec.if_valid    <= 1'b0;
            dec.if_instr    <= NOP_INSTR;
            dec.if_pc       <= 32'd0;
            dec.if_pc_plus4 <= 32'd4;
            fetch_fault     <= 1'b0;
            fetch_count     <= 32'd0;
        end else if (redirect_valid) begin
            dec.if_valid <= 1'b0;
            dec.if_instr <= NOP_INSTR;
            if (misalign) begin
                state       <= FAULT;
                fetch_fault <= 1'b1;
            end else begin
                state       <= run ? FETCH : IDLE;
                fetch_fault <= 1'b0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        state <= FETCH;
                    end
                    if (dec.if_valid && dec.if_ready) begin
                        dec.if_valid <= 1'b0;
                        dec.if_instr <= NOP_INSTR;
                    end
                end
                FETCH: begin
                    if (!run) begin
                        state <= IDLE;
                        if (dec.if_valid && dec.if_ready) begin
                            dec.if_valid <= 1'b0;
                            dec.if_instr <= NOP_INSTR;
                        end
                    end else if (ld) begin
                        dec.if_valid    <= 1'b1;
                        dec.if_instr    <= imem_rdata;
                        dec.if_pc       <= pc;
                        dec.if_pc_plus4 <= pc + 32'd4;
                        fetch_count     <= fetch_count + 32'd1;
                    end
                end
                FAULT: begin
                    dec.if_valid <= 1'b0;
                    dec.if_instr <= NOP_INSTR;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage: streaming, stall, redirect, fault, run gating, wrap, async reset.
module tb_ifetch_stage;
    import riscv_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [31:0] imem_addr;
    logic        imem_rw;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    int checks   = 0;
    int failures = 0;

    ifetch_stage_if dec ();

    ifetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .run            (run),
        .imem_addr      (imem_addr),
        .imem_rw        (imem_rw),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec            (dec.master),
        .fetch_fault    (fetch_fault),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    // Words outside the program return a recognisable pattern tagged with the low address bits.
    always_comb begin
        case (imem_addr)
            32'd0:   imem_rdata = 32'h0010_8093;
            32'd1:   imem_rdata = 32'h0011_0113;
            32'd2:   imem_rdata = 32'h0020_8133;
            32'd3:   imem_rdata = 32'h0020_80b3;
            32'd4:   imem_rdata = 32'hffdf_f1ef;
            default: imem_rdata = {16'hABCD, imem_addr[15:0]};
        endcase
    end

    task automatic applyStimulus(input logic run_v, input logic ready_v,
                                 input logic redir_v, input logic [31:0] redir_pc);
        run            = run_v;
        dec.if_ready   = ready_v;
        redirect_valid = redir_v;
        redirect_pc    = redir_pc;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkFetch(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                              input logic [31:0] count);
        checkOutput({tag, " valid"}, {31'd0, dec.if_valid}, 32'd1);
        checkOutput({tag, " instr"}, dec.if_instr, instr);
        checkOutput({tag, " pc"}, dec.if_pc, pc);
        checkOutput({tag, " pc+4"}, dec.if_pc_plus4, pc + 32'd4);
        checkOutput({tag, " count"}, fetch_count, count);
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        #2;
        checkOutput("rst valid", {31'd0, dec.if_valid}, 32'd0);
        checkOutput("rst instr", dec.if_instr, 32'h0000_0013);
        checkOutput("rst pc", dec.if_pc, 32'd0);
        checkOutput("rst pc+4", dec.if_pc_plus4, 32'd4);
        checkOutput("rst count", fetch_count, 32'd0);
        checkOutput("rst fault", {31'd0, fetch_fault}, 32'd0);
        checkOutput("rst addr", imem_addr, 32'd0);
        checkOutput("rst rw", {31'd0, imem_rw}, 32'd1);

        #1;
        reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        stepClock();
        checkOutput("idle->fetch valid", {31'd0, dec.if_valid}, 32'd0);

        // Streaming, one instruction per cycle
        stepClock();
        checkFetch("s0", 32'h0010_8093, 32'd0, 32'd1);
        checkOutput("s0 addr", imem_addr, 32'd1);
        stepClock();
        checkFetch("s1", 32'h0011_0113, 32'd4, 32'd2);
        stepClock();
        checkFetch("s2", 32'h0020_8133, 32'd8, 32'd3);

        // Stall for three cycles with if_pc=8 held
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            stepClock();
            checkFetch("stall", 32'h0020_8133, 32'd8, 32'd3);
            checkOutput("stall addr", imem_addr, 32'd3);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        stepClock();
        checkFetch("release", 32'h0020_80b3, 32'd12, 32'd4);
        stepClock();
        checkFetch("s4", 32'hffdf_f1ef, 32'd16, 32'd5);

        // Redirect back to 12 while 16 is held
        applyStimulus(1'b1, 1'b0, 1'b1, 32'd12);
        stepClock();
        checkOutput("redir valid", {31'd0, dec.if_valid}, 32'd0);
        checkOutput("redir instr", dec.if_instr, 32'h0000_0013);
        checkOutput("redir addr", imem_addr, 32'd3);
        checkOutput("redir count", fetch_count, 32'd5);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        stepClock();
        checkFetch("after redir", 32'h0020_80b3, 32'd12, 32'd6);

        // Misaligned redirect parks the stage in FAULT
        applyStimulus(1'b1, 1'b1, 1'b1, 32'd6);
        stepClock();
        checkOutput("mis fault", {31'd0, fetch_fault}, 32'd1);
        checkOutput("mis valid", {31'd0, dec.if_valid}, 32'd0);
        checkOutput("mis addr", imem_addr, 32'd4);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 2; i++) begin
            stepClock();
            checkOutput("fault valid", {31'd0, dec.if_valid}, 32'd0);
            checkOutput("fault sticky", {31'd0, fetch_fault}, 32'd1);
            checkOutput("fault count", fetch_count, 32'd6);
            checkOutput("fault addr", imem_addr, 32'd4);
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 32'd0);
        stepClock();
        checkOutput("clear fault", {31'd0, fetch_fault}, 32'd0);
        checkOutput("clear addr", imem_addr, 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        stepClock();
        checkFetch("resume", 32'h0010_8093, 32'd0, 32'd7);

        // Run gating: held instruction stays, then drains on if_ready
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        stepClock();
        checkFetch("run0 hold", 32'h0010_8093, 32'd0, 32'd7);
        stepClock();
        checkFetch("idle hold", 32'h0010_8093, 32'd0, 32'd7);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
        stepClock();
        checkOutput("drain valid", {31'd0, dec.if_valid}, 32'd0);
        checkOutput("drain instr", dec.if_instr, 32'h0000_0013);
        checkOutput("drain addr", imem_addr, 32'd1);
        stepClock();
        checkOutput("idle count", fetch_count, 32'd7);

        // PC wrap at the top of the address space
        applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        stepClock();
        checkOutput("wrap addr", imem_addr, 32'h3FFF_FFFF);
        checkOutput("wrap valid", {31'd0, dec.if_valid}, 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        stepClock();
        checkFetch("wrap top", 32'hABCD_FFFF, 32'hFFFF_FFFC, 32'd8);
        checkOutput("wrap next addr", imem_addr, 32'd0);
        stepClock();
        checkFetch("wrap zero", 32'h0010_8093, 32'd0, 32'd9);

        // Asynchronous reset in the middle of a stall, between clock edges
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        stepClock();
        checkFetch("pre-reset stall", 32'h0010_8093, 32'd0, 32'd9);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("areset valid", {31'd0, dec.if_valid}, 32'd0);
        checkOutput("areset instr", dec.if_instr, 32'h0000_0013);
        checkOutput("areset count", fetch_count, 32'd0);
        checkOutput("areset addr", imem_addr, 32'd0);
        stepClock();
        checkOutput("reset held valid", {31'd0, dec.if_valid}, 32'd0);
        reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        stepClock();
        checkOutput("post-reset idle", {31'd0, dec.if_valid}, 32'd0);
        stepClock();
        checkFetch("post-reset", 32'h0010_8093, 32'd0, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifetch_stage.md
Name: ifetch_stage

Overview:
- Instruction fetch stage sitting directly downstream of the instruction memory and upstream of decode.
- Holds the PC and drives the imem word address. Imem read is combinational, so each PC is sampled the same cycle.
- Captures instruction and PC into a one-entry output register with a valid/ready handshake to decode.
- Handles stalls, redirects (branch/jump from execute), start/stop control and misaligned-target faults.

Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into the PC on reset; must be 4-byte aligned.
- NOP_INSTR, 32'h0000_0013, value driven on if_instr whenever no valid instruction is held (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  1 = fetch enabled; 0 = stop issuing new fetches.
- imem_addr  out  32  word address to imem = {2'b00, pc[31:2]}.
- imem_rw  out  1  tied 1 (read); this stage never writes imem.
- imem_rdata  in  32  combinational instruction word for imem_addr.
- redirect_valid  in  1  1-cycle pulse: load redirect_pc, squash held instruction.
- redirect_pc  in  32  new byte PC.
- if_valid  out  1  output register holds a valid instruction.
- if_ready  in  1  decode accepts this cycle.
- if_instr  out  32  fetched instruction.
- if_pc  out  32  byte PC of if_instr.
- if_pc_plus4  out  32  if_pc + 4, mod 2^32.
- fetch_fault  out  1  sticky misaligned-redirect flag.
- fetch_count  out  32  number of instructions captured, wraps mod 2^32.

Behaviour:
- Async reset values:
  - pc = RESET_PC; state = IDLE.
  - if_valid = 0; if_instr = NOP_INSTR; if_pc = 0; if_pc_plus4 = 4.
  - fetch_fault = 0; fetch_count = 0.
- imem_addr is combinational from pc in every state. imem_rw = 1 always.
- FSM states: IDLE, FETCH, FAULT.
- IDLE:
  - No capture.
  - run=1 -> FETCH next cycle; the first capture happens in the first FETCH cycle.
  - A held valid instruction stays until accepted.
- FETCH: load condition ld = !if_valid || if_ready.
  - ld=1 and no redirect: capture if_instr <= imem_rdata, if_pc <= pc, if_valid <= 1, pc <= pc+4, fetch_count++.
  - Steady-state throughput is one instruction per cycle with if_ready held 1.
  - ld=0 (stall): pc, output register and count hold. imem_addr stays on the unconsumed pc.
  - run=0: no capture this cycle; -> IDLE. An accepted instruction still drops if_valid (if_valid <= 0 when if_ready).
- Latency: instruction at pc appears on if_instr one clock after pc is presented.
- redirect_valid=1 has priority over everything except reset:
  - Valid in FETCH, IDLE and FAULT.
  - Aligned target (redirect_pc[1:0]==0): pc <= redirect_pc; if_valid <= 0; if_instr <= NOP_INSTR; no capture that cycle. State becomes FETCH if run=1, else IDLE. fetch_fault clears.
  - Misaligned target: pc unchanged; if_valid <= 0; state -> FAULT; fetch_fault <= 1.
- Redirect with if_valid & if_ready in the same cycle: the held instruction counts as killed. Decode must discard it.
- FAULT:
  - No fetches; if_valid = 0.
  - Exits only via reset or an aligned redirect.
- PC wraps 32'hFFFF_FFFC -> 0 with no flag. fetch_count wraps to 0.
- Reset asserted mid-stall or mid-redirect: all state returns to reset values immediately (asynchronous). The fetch at RESET_PC resumes only after reset deasserts and run=1.

Decomposition:
- Shared package riscv_fetch_pkg holds:
  - fetch state enum {IDLE, FETCH, FAULT}.
  - NOP_INSTR constant.
  - RESET_PC default.
  - INSTR_W = 32.
- One natural sub-module: ifetch_pc_gen. It holds the pc register, next-pc mux (hold / +4 / redirect) and alignment check, and outputs pc and misalign.
- The FSM and output register stay in ifetch_stage.

Test Plan:
- Streaming: imem model preloaded with 00108093, 00110113, 00208133, 002080b3, ffdff1ef; reset, run=1, if_ready=1.
  - if_instr = 00108093 @ if_pc 0, then 00110113 @ 4, and so on, one per cycle.
  - fetch_count = 5 after five captures.
- Stall: hold if_ready=0 for 3 cycles while if_valid=1 with if_pc=8.
  - if_instr stays 00208133 and imem_addr stays 3.
  - Release: next captured is 002080b3 @ 12, with no skip or duplicate.
- Redirect: pulse redirect_valid with redirect_pc=12 while if_pc=16 is held.
  - Next cycle if_valid=0 and if_instr=00000013.
  - Following cycle if_instr=002080b3 @ if_pc 12.
  - The squashed instruction is never counted as accepted.
- Misaligned: redirect_pc=6.
  - fetch_fault=1, if_valid stays 0, pc unchanged.
  - A later redirect_pc=0 clears fetch_fault and resumes at 00108093.
- Run gating and wrap:
  - run=0 mid-stream: no new captures; the held instruction drains on if_ready.
  - Redirect to 32'hFFFF_FFFC with run=1: imem_addr shows 32'h3FFF_FFFF, then 0 on the next fetch.
- Async reset: assert reset mid-stall.
  - Outputs immediately become if_valid=0, if_instr=00000013, fetch_count=0, imem_addr=0, independent of clk.
